// File: rtl/phase_ctrl_pkg.sv
// Shared constants for the crossroad phase sequencer:
// state codes, light codes and default phase durations.
package phase_ctrl_pkg;

  localparam int WDOG_W = 8;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_GREEN  = 3'd1;
  localparam logic [2:0] ST_YELLOW = 3'd2;
  localparam logic [2:0] ST_RED    = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;
  localparam logic [1:0] LIGHT_FAULT  = 2'b11;

  localparam logic [7:0] DEF_GREEN_T   = 8'h25;
  localparam logic [7:0] DEF_YELLOW_T  = 8'h03;
  localparam logic [7:0] DEF_RED_T     = 8'h20;
  localparam logic [7:0] DEF_RED_PED_T = 8'h35;
  localparam logic [7:0] DEF_WDOG_MAX  = 8'd120;

endpackage

// File: rtl/phase_ctrl_wdog_cnt.sv
// Saturating binary cycle counter used as the
// per-phase watchdog of phase_ctrl.
module wdog_cnt #(
  parameter int         W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         max
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != MAX) begin
      count <= count + 1'b1;
    end
  end

  assign max = (count == MAX);

endmodule

// File: rtl/phase_ctrl.sv
// Traffic-phase sequencer: loads the BCD down counter per
// phase, advances on its terminal pulse, grants walk phases.
module phase_ctrl
  import phase_ctrl_pkg::*;
#(
  parameter logic [7:0] GREEN_T   = DEF_GREEN_T,
  parameter logic [7:0] YELLOW_T  = DEF_YELLOW_T,
  parameter logic [7:0] RED_T     = DEF_RED_T,
  parameter logic [7:0] RED_PED_T = DEF_RED_PED_T,
  parameter logic [7:0] WDOG_MAX  = DEF_WDOG_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       cin,
  input  logic       ped_req,
  output logic       load,
  output logic [7:0] data,
  output logic [1:0] light,
  output logic       ped_ack,
  output logic       walk
);

  logic [2:0]        state;
  logic [2:0]        nxt;
  logic              entry;
  logic              go;
  logic              fault_hit;
  logic              grant;
  logic              ped_ok;
  logic              ped_pend;
  logic [WDOG_W-1:0] wdog_count;
  logic              wdog_max;

  wdog_cnt #(
    .W   (WDOG_W),
    .MAX (WDOG_MAX)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (entry),
    .en    (en),
    .count (wdog_count),
    .max   (wdog_max)
  );

  // a cin seen while load is still high belongs to the old phase
  always_comb begin
    go        = en && cin && !load;
    fault_hit = en && (wdog_max ||
                wdog_count == WDOG_MAX - 8'd1);
    nxt       = state;
    entry     = 1'b0;
    case (state)
      ST_INIT: begin
        if (en) begin
          nxt   = ST_GREEN;
          entry = 1'b1;
        end
      end
      ST_GREEN: begin
        if (go) begin
          nxt   = ST_YELLOW;
          entry = 1'b1;
        end else if (fault_hit) begin
          nxt = ST_FAULT;
        end
      end
      ST_YELLOW: begin
        if (go) begin
          nxt   = ST_RED;
          entry = 1'b1;
        end else if (fault_hit) begin
          nxt = ST_FAULT;
        end
      end
      ST_RED: begin
        if (go) begin
          nxt   = ST_GREEN;
          entry = 1'b1;
        end else if (fault_hit) begin
          nxt = ST_FAULT;
        end
      end
      ST_FAULT: nxt = ST_FAULT;
      default:  nxt = ST_FAULT;
    endcase
    grant  = entry && (nxt == ST_RED) && ped_pend;
    ped_ok = en && ped_req &&
             ((state == ST_GREEN) ||
              (state == ST_YELLOW) ||
              (state == ST_RED && !walk));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      light    <= LIGHT_RED;
      load     <= 1'b0;
      data     <= 8'h00;
      ped_ack  <= 1'b0;
      walk     <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      state   <= nxt;
      load    <= entry;
      ped_ack <= grant;
      if (entry) begin
        unique case (1'b1)
          nxt == ST_GREEN: begin
            light <= LIGHT_GREEN;
            data  <= GREEN_T;
            walk  <= 1'b0;
          end
          nxt == ST_YELLOW: begin
            light <= LIGHT_YELLOW;
            data  <= YELLOW_T;
          end
          default: begin
            light <= LIGHT_RED;
            data  <= ped_pend ? RED_PED_T : RED_T;
            walk  <= ped_pend;
          end
        endcase
      end else if (nxt == ST_FAULT) begin
        light <= LIGHT_FAULT;
        walk  <= 1'b0;
      end
      // a request on the granting edge is dropped
      if (grant) begin
        ped_pend <= 1'b0;
      end else if (ped_ok) begin
        ped_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase_ctrl.sv
// Directed bench for phase_ctrl: phase sequence, walk
// grants, enable freeze, watchdog fault and async reset.
module tb_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cin;
  logic       ped_req;
  logic       load;
  logic [7:0] data;
  logic [1:0] light;
  logic       ped_ack;
  logic       walk;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phase_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .cin     (cin),
    .ped_req (ped_req),
    .load    (load),
    .data    (data),
    .light   (light),
    .ped_ack (ped_ack),
    .walk    (walk)
  );

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic expect_phase(input string tag,
                              input logic [1:0] l,
                              input logic [7:0] d,
                              input logic w,
                              input logic a);
    check({tag, "_load"}, {7'd0, load}, 8'd1);
    check({tag, "_light"}, {6'd0, light}, {6'd0, l});
    check({tag, "_data"}, data, d);
    check({tag, "_walk"}, {7'd0, walk}, {7'd0, w});
    check({tag, "_ack"}, {7'd0, ped_ack}, {7'd0, a});
  endtask

  // called on the cycle load is seen high; cin one cycle later
  task automatic advance();
    cin = 1'b0;
    cyc();
    check("load_1cyc", {7'd0, load}, 8'd0);
    check("ack_1cyc", {7'd0, ped_ack}, 8'd0);
    cin = 1'b1;
    cyc();
    cin = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    cin = 1'b0;
    ped_req = 1'b0;
    repeat (2) cyc();
    check("rst_light", {6'd0, light}, 8'h02);
    check("rst_load", {7'd0, load}, 8'd0);
    check("rst_data", data, 8'h00);
    check("rst_walk", {7'd0, walk}, 8'd0);
    check("rst_ack", {7'd0, ped_ack}, 8'd0);

    // INIT holds while en=0
    rst = 1'b0;
    repeat (2) cyc();
    check("init_hold_light", {6'd0, light}, 8'h02);
    check("init_hold_load", {7'd0, load}, 8'd0);
    en = 1'b1;
    cyc();
    expect_phase("g1", 2'b00, 8'h25, 1'b0, 1'b0);
    advance();
    expect_phase("y1", 2'b01, 8'h03, 1'b0, 1'b0);
    advance();
    expect_phase("r1", 2'b10, 8'h20, 1'b0, 1'b0);
    advance();
    expect_phase("g2", 2'b00, 8'h25, 1'b0, 1'b0);

    // pedestrian pulse mid-GREEN
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    check("ped_g_load", {7'd0, load}, 8'd0);
    advance();
    expect_phase("y2", 2'b01, 8'h03, 1'b0, 1'b0);
    advance();
    expect_phase("r2", 2'b10, 8'h35, 1'b1, 1'b1);
    advance();
    expect_phase("g3", 2'b00, 8'h25, 1'b0, 1'b0);
    advance();
    expect_phase("y3", 2'b01, 8'h03, 1'b0, 1'b0);
    advance();
    expect_phase("r3", 2'b10, 8'h20, 1'b0, 1'b0);

    // request in normal red is served next round
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    advance();
    expect_phase("g4", 2'b00, 8'h25, 1'b0, 1'b0);
    advance();
    expect_phase("y4", 2'b01, 8'h03, 1'b0, 1'b0);
    advance();
    expect_phase("r4", 2'b10, 8'h35, 1'b1, 1'b1);

    // held through walk red into green: served again
    ped_req = 1'b1;
    cyc();
    check("walk_hold_ack", {7'd0, ped_ack}, 8'd0);
    check("walk_hold_walk", {7'd0, walk}, 8'd1);
    advance();
    expect_phase("g5", 2'b00, 8'h25, 1'b0, 1'b0);
    advance();
    ped_req = 1'b0;
    expect_phase("y5", 2'b01, 8'h03, 1'b0, 1'b0);
    advance();
    expect_phase("r5", 2'b10, 8'h35, 1'b1, 1'b1);

    // held during walk red, dropped before green: not served
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    advance();
    expect_phase("g6", 2'b00, 8'h25, 1'b0, 1'b0);
    advance();
    expect_phase("y6", 2'b01, 8'h03, 1'b0, 1'b0);

    // en low for 10 cycles from the yellow load, cin inside
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cin = (i >= 3 && i <= 5);
      cyc();
      check($sformatf("en0_light_%0d", i),
            {6'd0, light}, 8'h01);
      check($sformatf("en0_load_%0d", i),
            {7'd0, load}, 8'd0);
    end
    cin = 1'b0;
    en = 1'b1;
    cyc();
    check("en1_light", {6'd0, light}, 8'h01);
    check("en1_load", {7'd0, load}, 8'd0);
    cin = 1'b1;
    cyc();
    cin = 1'b0;
    expect_phase("r6", 2'b10, 8'h20, 1'b0, 1'b0);

    // cin coincident with load is stale; then watchdog
    cin = 1'b1;
    cyc();
    cin = 1'b0;
    check("stale_load", {7'd0, load}, 8'd0);
    check("stale_light", {6'd0, light}, 8'h02);
    repeat (118) cyc();
    check("wd_119_light", {6'd0, light}, 8'h02);
    cyc();
    check("wd_fault_light", {6'd0, light}, 8'h03);
    check("wd_fault_load", {7'd0, load}, 8'd0);
    check("wd_fault_walk", {7'd0, walk}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      cin = 1'b1;
      cyc();
      cin = 1'b0;
      cyc();
      check($sformatf("fault_cin_light_%0d", i),
            {6'd0, light}, 8'h03);
      check($sformatf("fault_cin_load_%0d", i),
            {7'd0, load}, 8'd0);
    end
    #2 rst = 1'b1;
    #1;
    check("frst_light", {6'd0, light}, 8'h02);
    check("frst_data", data, 8'h00);
    check("frst_load", {7'd0, load}, 8'd0);
    cyc();
    rst = 1'b0;
    cyc();
    expect_phase("g7", 2'b00, 8'h25, 1'b0, 1'b0);

    // async reset mid walk red with request held
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    advance();
    expect_phase("y7", 2'b01, 8'h03, 1'b0, 1'b0);
    advance();
    expect_phase("r7", 2'b10, 8'h35, 1'b1, 1'b1);
    ped_req = 1'b1;
    cyc();
    #2 rst = 1'b1;
    #1;
    check("mrst_light", {6'd0, light}, 8'h02);
    check("mrst_walk", {7'd0, walk}, 8'd0);
    check("mrst_data", data, 8'h00);
    check("mrst_load", {7'd0, load}, 8'd0);
    check("mrst_ack", {7'd0, ped_ack}, 8'd0);
    ped_req = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    expect_phase("g8", 2'b00, 8'h25, 1'b0, 1'b0);
    advance();
    expect_phase("y8", 2'b01, 8'h03, 1'b0, 1'b0);
    advance();
    expect_phase("r8", 2'b10, 8'h20, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
